// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*       : ALU operand source encodings for fwdA/fwdB
//   MD_*_CYC    : busy-cycle counts of the multi-cycle mult/div unit
//   md_state_t  : mult/div occupancy FSM states
//   fwd_sel     : forwarding priority rule (MEM over WB, r0 never forwarded)
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int MD_MUL_CYC = 4;
    localparam int MD_DIV_CYC = 32;

    // Down-counter reload values: the counter runs load..0 inclusive.
    localparam logic [4:0] MD_MUL_LOAD = 5'(MD_MUL_CYC - 1);
    localparam logic [4:0] MD_DIV_LOAD = 5'(MD_DIV_CYC - 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_reg,
        input logic       wb_we,
        input logic [4:0] wb_reg,
        input logic [4:0] src
    );
        if (mem_we && (mem_reg != 5'd0) && (mem_reg == src))
            return FWD_MEM;
        else if (wb_we && (wb_reg != 5'd0) && (wb_reg == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Occupancy timer for the multi-cycle mult/div unit.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : mult/div instruction present in EX
//   is_div   : the EX instruction is a divide (long latency)
//   md_busy  : unit occupied
//
// state   | meaning
// MD_IDLE | unit free, waiting for a mult/div in EX
// MD_BUSY | unit occupied, md_cnt counting down to 0
module md_busy_timer
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    md_state_t  state_q, state_d;
    logic [4:0] md_cnt, md_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            md_cnt  <= 5'd0;
        end else begin
            state_q <= state_d;
            md_cnt  <= md_cnt_d;
        end
    end

    // A start while busy cannot happen (ID stalls it) and is ignored.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = is_div ? MD_DIV_LOAD : MD_MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt == 5'd0)
                    state_d = MD_IDLE;
                else
                    md_cnt_d = md_cnt - 5'd1;
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = 5'd0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, redirect
// flushes, EX operand forwarding and a saturating stall-cycle counter.
//   clk, rst                       : clock, asynchronous active-low reset
//   id_*                           : instruction in ID (sources, kind)
//   ex_*                           : ID/EX register contents
//   ex_redirect                    : taken branch/jump resolved in EX
//   mem_/wb_regWrite, mem_/wb_wreg : later-stage writers
//   pc_write, ifid_write           : PC / IF-ID load enables
//   ifid_flush, idex_flush         : bubble insertion
//   fwdA, fwdB                     : ALU operand select
//   md_busy, stall_count           : mult/div occupancy, stall counter
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_useRs,
    input  logic        id_useRt,
    input  logic        id_isMulDiv,
    input  logic        id_isMfhiLo,
    input  logic        ex_memRead,
    input  logic        ex_regWrite,
    input  logic        ex_isMulDiv,
    input  logic        ex_isDiv,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_redirect,
    input  logic        mem_regWrite,
    input  logic        wb_regWrite,
    input  logic [4:0]  mem_wreg,
    input  logic [4:0]  wb_wreg,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    logic load_use;
    logic md_hazard;
    logic stall;

    // EX destination fields are part of the ID/EX bundle but not needed here.
    logic unused_ex_dest;
    assign unused_ex_dest = ^{ex_regWrite, ex_wreg};

    md_busy_timer u_md_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (ex_isMulDiv),
        .is_div  (ex_isDiv),
        .md_busy (md_busy)
    );

    assign load_use  = ex_memRead && (ex_rt != 5'd0) &&
                       ((id_useRs && (id_rs == ex_rt)) ||
                        (id_useRt && (id_rt == ex_rt)));
    assign md_hazard = (id_isMulDiv || id_isMfhiLo) && (md_busy || ex_isMulDiv);
    assign stall     = load_use || md_hazard;

    // Reset holds the front end frozen with both pipeline registers flushed.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwdA       = FWD_REG;
        fwdB       = FWD_REG;
        if (!rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            fwdA = fwd_sel(mem_regWrite, mem_wreg, wb_regWrite, wb_wreg, ex_rs);
            fwdB = fwd_sel(mem_regWrite, mem_wreg, wb_regWrite, wb_wreg, ex_rt);
            if (ex_redirect) begin
                // Redirect wins: the stalled ID instruction is on the wrong path.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (stall) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= 32'd0;
        else if (stall && !ex_redirect && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic        id_useRs, id_useRt, id_isMulDiv, id_isMfhiLo;
    logic        ex_memRead, ex_regWrite, ex_isMulDiv, ex_isDiv, ex_redirect;
    logic        mem_regWrite, wb_regWrite;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, md_busy;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] stall_count;

    int checks = 0;
    int failures = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
        .id_isMulDiv(id_isMulDiv), .id_isMfhiLo(id_isMfhiLo),
        .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
        .ex_isMulDiv(ex_isMulDiv), .ex_isDiv(ex_isDiv),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_redirect(ex_redirect),
        .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
        .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwdA(fwdA), .fwdB(fwdB), .md_busy(md_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // md_left = number of busy cycles still ahead (0 means unit free).
    int          md_left = 0;
    logic [31:0] m_count = 32'd0;

    function automatic logic m_stall();
        logic lu, md;
        lu = ex_memRead && ex_rt != 0 &&
             ((id_useRs && id_rs == ex_rt) || (id_useRt && id_rt == ex_rt));
        md = (id_isMulDiv || id_isMfhiLo) && (md_left > 0 || ex_isMulDiv);
        return lu || md;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (mem_regWrite && mem_wreg != 0 && mem_wreg == src) return 2'd1;
        if (wb_regWrite && wb_wreg != 0 && wb_wreg == src) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_left = 0;
            m_count = 32'd0;
        end else begin
            if (m_stall() && !ex_redirect && m_count != 32'hFFFF_FFFF)
                m_count = m_count + 1;
            if (md_left > 0) md_left = md_left - 1;
            else if (ex_isMulDiv) md_left = ex_isDiv ? 32 : 4;
        end
    end

    always @(negedge clk) begin
        logic e_pc, e_ifw, e_iff, e_idf;
        logic [1:0] e_fa, e_fb;
        if (!rst) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_fa = 0; e_fb = 0;
        end else begin
            e_fa = m_fwd(ex_rs);
            e_fb = m_fwd(ex_rt);
            if (ex_redirect) begin
                e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
            end else if (m_stall()) begin
                e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
            end else begin
                e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
            end
        end
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush), 32'(e_idf));
        chk("fwdA", 32'(fwdA), 32'(e_fa));
        chk("fwdB", 32'(fwdB), 32'(e_fb));
        chk("md_busy", 32'(md_busy), 32'(md_left > 0));
        chk("stall_count", stall_count, m_count);
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_useRs = 0; id_useRt = 0;
        id_isMulDiv = 0; id_isMfhiLo = 0;
        ex_memRead = 0; ex_regWrite = 0; ex_isMulDiv = 0; ex_isDiv = 0;
        ex_rs = 0; ex_rt = 0; ex_wreg = 0; ex_redirect = 0;
        mem_regWrite = 0; wb_regWrite = 0; mem_wreg = 0; wb_wreg = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        ex_memRead = 1; ex_rt = 8; id_rs = 8; id_useRs = 1;
    endtask

    initial begin
        int busy_n, stall_n;
        rst = 0;
        clear_inputs();
        @(negedge clk);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rst_stall_count", stall_count, 32'd0);
        next_cycle();
        rst = 1;

        // Load-use stall
        next_cycle();
        set_load_use();
        @(negedge clk);
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_idex_flush", 32'(idex_flush), 32'd1);
        next_cycle();
        clear_inputs();
        #1;
        chk("lu_count", stall_count, 32'd1);
        chk("lu_released", 32'(pc_write), 32'd1);

        // Load into r0 never stalls
        set_load_use();
        ex_rt = 0; id_rs = 0;
        @(negedge clk);
        chk("r0_pc_write", 32'(pc_write), 32'd1);
        next_cycle();
        clear_inputs();
        chk("r0_count", stall_count, 32'd1);

        // Redirect overrides load-use
        set_load_use();
        ex_redirect = 1;
        @(negedge clk);
        chk("rd_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rd_pc_write", 32'(pc_write), 32'd1);
        next_cycle();
        clear_inputs();
        chk("rd_count", stall_count, 32'd1);

        // Forwarding
        ex_rs = 5; ex_rt = 5; mem_wreg = 5; wb_wreg = 5;
        mem_regWrite = 1; wb_regWrite = 1;
        #1 chk("fwd_mem", 32'(fwdA), 32'd1);
        mem_regWrite = 0;
        #1 chk("fwd_wb", 32'(fwdA), 32'd2);
        mem_regWrite = 1; mem_wreg = 0;
        #1 chk("fwd_mem_r0", 32'(fwdB), 32'd2);
        ex_rs = 6;
        #1 chk("fwd_none", 32'(fwdA), 32'd0);
        next_cycle();
        clear_inputs();

        // Divide, then mfhi waits for all 32 busy cycles
        ex_isMulDiv = 1; ex_isDiv = 1;
        next_cycle();
        clear_inputs();
        id_isMfhiLo = 1;
        busy_n = 0; stall_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!md_busy) begin
                chk("div_after_pc_write", 32'(pc_write), 32'd1);
                break;
            end
            busy_n++;
            if (!pc_write) stall_n++;
        end
        chk("div_busy_cycles", 32'(busy_n), 32'd32);
        chk("div_stall_cycles", 32'(stall_n), 32'd32);
        chk("div_count", stall_count, 32'd33);
        next_cycle();
        clear_inputs();

        // Reset during busy cycle 10, then a multiply
        ex_isMulDiv = 1; ex_isDiv = 1;
        next_cycle();
        clear_inputs();
        repeat (9) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("arst_md_busy", 32'(md_busy), 32'd0);
        chk("arst_count", stall_count, 32'd0);
        chk("arst_idex_flush", 32'(idex_flush), 32'd1);
        next_cycle();
        rst = 1;
        next_cycle();
        ex_isMulDiv = 1; id_isMulDiv = 1;
        @(negedge clk);
        chk("mul_issue_stall", 32'(pc_write), 32'd0);
        next_cycle();
        clear_inputs();
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (md_busy) busy_n++;
        end
        chk("mul_busy_cycles", 32'(busy_n), 32'd4);
        chk("mul_count", stall_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL use one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-002 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-003 id_useRs, id_useRt  in  1 each  ID instruction reads rs/rt.
REQ-004 id_isMulDiv, id_isMfhiLo  in  1 each  ID holds mult/div, or mfhi/mflo.
REQ-005 ex_memRead, ex_regWrite, ex_isMulDiv, ex_isDiv  in  1 each  ID/EX register control outputs.
REQ-006 ex_rs, ex_rt, ex_wreg  in  5 each  EX-stage source and destination register numbers.
REQ-007 ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-008 mem_regWrite, wb_regWrite  in  1 each; mem_wreg, wb_wreg  in  5 each  later-stage writers.
REQ-009 pc_write, ifid_write  out  1 each  PC / IF-ID load enables.
REQ-010 ifid_flush, idex_flush  out  1 each  bubble insert into IF/ID, ID/EX.
REQ-011 fwdA, fwdB  out  2 each  ALU operand select: 00 regfile, 01 MEM, 10 WB.
REQ-012 md_busy  out  1  mult/div unit occupied; stall_count  out  32  stall-cycle counter.

Function
REQ-013 Load-use hazard: ex_memRead and ex_rt!=0 and ((id_useRs and id_rs==ex_rt) or (id_useRt and id_rt==ex_rt)) SHALL assert stall.
REQ-014 Mul/div hazard: (id_isMulDiv or id_isMfhiLo) and (md_busy or ex_isMulDiv) SHALL assert stall.
REQ-015 Stall SHALL drive pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
REQ-016 ex_redirect SHALL drive pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1 and override any stall in the same cycle.
REQ-017 With no stall and no redirect: pc_write=1, ifid_write=1, both flushes 0.
REQ-018 fwdA SHALL be 01 if mem_regWrite and mem_wreg!=0 and mem_wreg==ex_rs; else 10 if wb_regWrite and wb_wreg!=0 and wb_wreg==ex_rs; else 00. MEM has priority. fwdB is identical on ex_rt.
REQ-019 Hazard, flush and forwarding outputs SHALL be combinational from inputs and the current FSM state (zero-cycle latency).
REQ-020 The mul/div FSM SHALL have states MD_IDLE and MD_BUSY, with a 5-bit down-counter md_cnt.
REQ-021 In MD_IDLE with ex_isMulDiv=1: go to MD_BUSY; md_cnt loads 31 if ex_isDiv, else 3.
REQ-022 In MD_BUSY: md_cnt decrements each cycle; at md_cnt==0 return to MD_IDLE on the next edge.
REQ-023 A multiply SHALL therefore occupy 4 busy cycles and a divide 32.
REQ-024 md_busy SHALL equal (state==MD_BUSY).
REQ-025 ex_isMulDiv in MD_BUSY is illegal (prevented by REQ-014); the FSM SHALL ignore it.
REQ-026 ex_redirect SHALL NOT abort an in-progress mul/div.
REQ-027 stall_count SHALL increment by 1 on each clock where REQ-013 or REQ-014 stall holds and ex_redirect=0.
REQ-028 stall_count SHALL saturate at 0xFFFFFFFF (no wrap).

Reset
REQ-029 rst=0 SHALL immediately force: state=MD_IDLE, md_cnt=0, stall_count=0, md_busy=0, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, fwdA=fwdB=00.
REQ-030 Reset asserted during MD_BUSY SHALL abandon the operation; after release the FSM is in MD_IDLE.
REQ-031 Outputs SHALL follow REQ-013..REQ-028 from the first rising clk edge after rst rises.

Structure
REQ-032 Package hazard_pkg SHALL hold FWD_REG/FWD_MEM/FWD_WB encodings, MD_MUL_CYC=4, MD_DIV_CYC=32, and the md_state_t enum.
REQ-033 Sub-module md_busy_timer SHALL contain the FSM and md_cnt, exposing md_busy; all other logic stays in hazard_ctrl.

Verification
REQ-034 Load-use: ex_memRead=1, ex_rt=8, id_rs=8, id_useRs=1 -> pc_write=0, idex_flush=1 for one cycle; stall_count 0->1.
REQ-035 Same as REQ-034 but ex_rt=0 -> no stall, and stall_count unchanged.
REQ-036 Redirect plus load-use in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1; stall_count unchanged.
REQ-037 ex_isDiv=1 pulse, then mfhi held in ID -> md_busy=1 for 32 cycles and stall for all of them; pc_write=1 the cycle after md_busy falls.
REQ-038 mem_wreg=wb_wreg=ex_rs=5 with both writing -> fwdA=01; with mem_regWrite=0 -> fwdA=10.
REQ-039 rst=0 at busy cycle 10 -> md_busy=0 asynchronously; after release, a mult gives exactly 4 busy cycles.
